// File: rtl/brq_pkg.sv
// Shared LSU types for the brq core: access data types, the response-stage
// state encoding and the rule deciding when an access needs two bus beats.
package brq_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'b00,
        LSU_HALF = 2'b01,
        LSU_BYTE = 2'b10
    } lsu_dtype_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_LO = 2'b01,
        WAIT_HI = 2'b10
    } lsu_resp_state_e;

    // A word at any non-zero offset, or a half at offset 3, crosses a word
    // boundary and is served by two bus beats. Bytes never cross.
    function automatic logic lsu_is_split(lsu_dtype_e dtype, logic [1:0] offset);
        return ((dtype == LSU_WORD) && (offset != 2'b00)) ||
               ((dtype == LSU_HALF) && (offset == 2'b11));
    endfunction

endpackage

// File: rtl/brq_lsu_align.sv
// Load data alignment: picks the addressed bytes out of a 64-bit window
// (hi beat : lo beat) and sign- or zero-extends them to 32 bits.
module brq_lsu_align
    import brq_pkg::*;
(
    input  logic [63:0] comb64,
    input  logic [1:0]  offset,
    input  logic [1:0]  dtype,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [31:0] raw;

    // Shift the addressed byte down to bit 0, then extend according to size.
    always_comb begin
        raw  = 32'(comb64 >> {offset, 3'b000});
        data = raw;
        case (lsu_dtype_e'(dtype))
            LSU_HALF: data = {{16{sign_ext & raw[15]}}, raw[15:0]};
            LSU_BYTE: data = {{24{sign_ext & raw[7]}}, raw[7:0]};
            default:  data = raw;
        endcase
    end

endmodule

// File: rtl/brq_lsu_resp.sv
// LSU response stage: tracks the single in-flight load/store, collects its
// one or two bus response beats and presents the aligned result to
// writeback combinationally in the final-beat cycle.
// Optional response counters are built when BRQ_LSU_RESP_PERF_EN is defined;
// otherwise the counter outputs are tied to zero.
module brq_lsu_resp
    import brq_pkg::*;
#(
    parameter int PerfCntW = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [1:0]          req_type_i,
    input  logic                req_sign_ext_i,
    input  logic [1:0]          req_offset_i,
    input  logic                data_rvalid_i,
    input  logic [31:0]         data_rdata_i,
    input  logic                data_err_i,
    output logic [31:0]         rf_wdata_lsu_o,
    output logic                rf_we_lsu_o,
    output logic                lsu_resp_valid_o,
    output logic                lsu_resp_err_o,
    output logic                busy_o,
    output logic [PerfCntW-1:0] perf_load_cnt_o,
    output logic [PerfCntW-1:0] perf_store_cnt_o,
    output logic [PerfCntW-1:0] perf_split_cnt_o
);

    lsu_resp_state_e state_q;
    lsu_dtype_e      type_q;
    logic            split_q;
    logic            we_q;
    logic            sign_ext_q;
    logic [1:0]      offset_q;
    logic [31:0]     lo_q;
    logic            err_q;

    logic            final_beat;
    logic            lo_beat;
    logic            accept;
    logic            resp_err;
    logic [63:0]     comb64;
    logic [31:0]     aligned;

    // Handshake and beat classification; a response in IDLE is never a beat.
    always_comb begin
        final_beat = data_rvalid_i &
                     ((state_q == WAIT_HI) | ((state_q == WAIT_LO) & ~split_q));
        lo_beat    = data_rvalid_i & (state_q == WAIT_LO) & split_q;
        accept     = req_valid_i & req_ready_o;
        resp_err   = final_beat & (err_q | data_err_i);
    end

    assign req_ready_o = (state_q == IDLE) | final_beat;

    // Descriptor capture, lo-beat buffering and state sequencing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            type_q     <= LSU_WORD;
            split_q    <= 1'b0;
            we_q       <= 1'b0;
            sign_ext_q <= 1'b0;
            offset_q   <= 2'b00;
            lo_q       <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            if (lo_beat) begin
                lo_q  <= data_rdata_i;
                err_q <= err_q | data_err_i;
            end
            if (accept) begin
                type_q     <= lsu_dtype_e'(req_type_i);
                split_q    <= lsu_is_split(lsu_dtype_e'(req_type_i), req_offset_i);
                we_q       <= req_we_i;
                sign_ext_q <= req_sign_ext_i;
                offset_q   <= req_offset_i;
                err_q      <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (data_rvalid_i) begin
                        if (split_q)     state_q <= WAIT_HI;
                        else if (accept) state_q <= WAIT_LO;
                        else             state_q <= IDLE;
                    end
                end
                WAIT_HI: begin
                    if (data_rvalid_i) state_q <= accept ? WAIT_LO : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // For a single-beat access both halves of the window hold the same word,
    // so the shift only ever exposes bytes from that beat.
    assign comb64 = {data_rdata_i, split_q ? lo_q : data_rdata_i};

    brq_lsu_align u_align (
        .comb64   (comb64),
        .offset   (offset_q),
        .dtype    (type_q),
        .sign_ext (sign_ext_q),
        .data     (aligned)
    );

    assign lsu_resp_valid_o = final_beat;
    assign lsu_resp_err_o   = resp_err;
    assign rf_we_lsu_o      = final_beat & ~we_q & ~resp_err;
    assign rf_wdata_lsu_o   = (final_beat & ~we_q) ? aligned : 32'h0;
    assign busy_o           = (state_q != IDLE);

`ifdef BRQ_LSU_RESP_PERF_EN
    logic [PerfCntW-1:0] load_cnt_q;
    logic [PerfCntW-1:0] store_cnt_q;
    logic [PerfCntW-1:0] split_cnt_q;
    logic                resp_ok;

    assign resp_ok = final_beat & ~resp_err;

    // Saturating counters of error-free completed accesses by kind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            split_cnt_q <= '0;
        end else if (resp_ok) begin
            if (~we_q && (load_cnt_q != {PerfCntW{1'b1}}))
                load_cnt_q <= load_cnt_q + PerfCntW'(1);
            if (we_q && (store_cnt_q != {PerfCntW{1'b1}}))
                store_cnt_q <= store_cnt_q + PerfCntW'(1);
            if (split_q && (split_cnt_q != {PerfCntW{1'b1}}))
                split_cnt_q <= split_cnt_q + PerfCntW'(1);
        end
    end

    assign perf_load_cnt_o  = load_cnt_q;
    assign perf_store_cnt_o = store_cnt_q;
    assign perf_split_cnt_o = split_cnt_q;
`else
    assign perf_load_cnt_o  = '0;
    assign perf_store_cnt_o = '0;
    assign perf_split_cnt_o = '0;
`endif

endmodule

// File: doc/brq_lsu_resp.md
Name: brq_lsu_resp

Overview:
- LSU response stage. Tracks the one in-flight load/store issued by the LSU request side and collects 1 or 2 data-bus response beats (2 when misaligned).
- Aligns and sign/zero-extends load data, then drives the writeback stage's LSU inputs: rf_wdata_lsu, rf_we_lsu, lsu_resp_valid, lsu_resp_err.
- Sits between the data bus response channel and the writeback unit.

Parameters:
- PerfCntW, 32, width of optional response counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  LSU issued the first bus request of an instruction
- req_ready_o  out  1  descriptor can be accepted
- req_we_i  in  1  1=store, 0=load
- req_type_i  in  2  brq_pkg::lsu_dtype_e: word/half/byte
- req_sign_ext_i  in  1  sign-extend load data
- req_offset_i  in  2  addr[1:0] of the access
- data_rvalid_i  in  1  bus response beat
- data_rdata_i  in  32  bus read data
- data_err_i  in  1  bus error on this beat
- rf_wdata_lsu_o  out  32  aligned load data
- rf_we_lsu_o  out  1  load result write enable
- lsu_resp_valid_o  out  1  instruction's final beat received
- lsu_resp_err_o  out  1  error on any beat
- busy_o  out  1  response outstanding
- perf_load_cnt_o  out  PerfCntW  completed loads (optional feature)
- perf_store_cnt_o  out  PerfCntW  completed stores (optional feature)
- perf_split_cnt_o  out  PerfCntW  completed split accesses (optional feature)

Behaviour:
- Reset (rst_ni async active-low): state IDLE, descriptor/data/error regs cleared. All outputs 0 except req_ready_o=1.
- Split rule: split = (word & offset!=0) | (half & offset==3). Byte accesses never split.
- Handshake: descriptor captured on req_valid_i & req_ready_o.
  - req_ready_o = (state==IDLE) | final_beat.
  - final_beat = data_rvalid_i & (state==WAIT_HI | (state==WAIT_LO & ~split_q)).
  - Back-to-back acceptance in the final-beat cycle is required.
- FSM:
  - IDLE -> WAIT_LO on accept.
  - WAIT_LO + rvalid: -> WAIT_HI if split_q; else -> IDLE, or -> WAIT_LO if a new descriptor is accepted that cycle.
  - WAIT_HI + rvalid: -> IDLE, or -> WAIT_LO on a same-cycle accept.
- data_rvalid_i in IDLE is ignored and has no effect on any output.
- Lo beat of a split access: store rdata in lo_q; err_q |= data_err_i.
- Outputs are combinational on the final beat (zero latency; writeback samples them in the same cycle):
  - lsu_resp_valid_o = final_beat.
  - lsu_resp_err_o = final_beat & (err_q | data_err_i).
  - rf_we_lsu_o = final_beat & ~req_we_q & ~lsu_resp_err_o.
- Alignment: comb64 = {data_rdata_i, split_q ? lo_q : data_rdata_i}; raw = comb64 >> (offset_q*8).
  - word: raw[31:0].
  - half: extend raw[15:0].
  - byte: extend raw[7:0].
  - Extend = sign if sign_ext_q, else zero.
- Stores: rf_wdata_lsu_o = 0, rf_we_lsu_o = 0.
- Errors do not shorten a split: both beats are always waited for. err_q clears on accept.
- busy_o = (state != IDLE).
- Reset mid-operation: returns to IDLE and drops the descriptor. No response is emitted for it.

Optional Feature:
- Macro BRQ_LSU_RESP_PERF_EN.
- Defined: three saturating PerfCntW counters increment on lsu_resp_valid_o & ~lsu_resp_err_o.
  - perf_load_cnt_o: loads.
  - perf_store_cnt_o: stores.
  - perf_split_cnt_o: split accesses.
  - All cleared by reset.
- Undefined: counters not instantiated; the three outputs tied to 0.

Decomposition:
- brq_pkg gains:
  - lsu_dtype_e (LSU_WORD=2'b00, LSU_HALF=2'b01, LSU_BYTE=2'b10).
  - lsu_resp_state_e (IDLE, WAIT_LO, WAIT_HI).
- One natural sub-module: brq_lsu_align, the combinational shift/extend taking comb64, offset, type and sign_ext.

Test Plan:
- Aligned word load (offset 0), rdata 0xDEADBEEF in the cycle after accept -> same cycle: resp_valid=1, we=1, wdata=0xDEADBEEF.
- Signed byte load, offset 2, rdata 0x0080_0000 -> wdata 0xFFFFFF80. Unsigned -> 0x00000080.
- Misaligned word load, offset 1: beats 0x44332211 then 0x88776655 -> resp_valid only on beat 2, wdata=0x55443322.
- Split half load, offset 3: lo beat has err=1, hi beat clean -> resp_valid=1, err=1, we=0 on beat 2.
- Store response, plus new load accepted in the same cycle -> resp_valid=1, we=0, req_ready_o=1, state WAIT_LO next cycle.
- Spurious rvalid in IDLE -> no outputs. Reset asserted in WAIT_HI -> busy_o=0, no resp_valid. With BRQ_LSU_RESP_PERF_EN, counters match the issued mix.
